// File: rtl/id_branch_resolver.sv
// ID-stage branch resolver: forwards operands, evaluates MIPS branch conditions,
// stalls on pending operands, tracks stall length and keeps saturating statistics.
module id_branch_resolver #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [DATA_WIDTH-1:0] Read_Data_1_ID,
  input  logic [DATA_WIDTH-1:0] Read_Data_2_ID,
  input  logic [DATA_WIDTH-1:0] Alu_Result_MEM,
  input  logic [DATA_WIDTH-1:0] Write_Data_WB,
  input  logic [1:0]            Forward_C_ID,
  input  logic [1:0]            Forward_D_ID,
  input  logic                  Branch_ID,
  input  logic [2:0]            Branch_Op_ID,
  input  logic                  Operand_Pending_ID,
  input  logic                  Clear_Stats,
  output logic                  Zero_ID,
  output logic                  Stall_ID,
  output logic                  Taken_ID,
  output logic                  Flush_IF,
  output logic                  Last_Taken,
  output logic                  Timeout_Err_ID,
  output logic [CNT_WIDTH-1:0]  Branch_Count,
  output logic [CNT_WIDTH-1:0]  Taken_Count,
  output logic [CNT_WIDTH-1:0]  Stall_Count
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0]     WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0]     WAIT_ZERO  = {WAIT_W{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [1:0]            sel,
    input logic [DATA_WIDTH-1:0] rf_val,
    input logic [DATA_WIDTH-1:0] mem_val,
    input logic [DATA_WIDTH-1:0] wb_val
  );
    case (sel)
      2'b01:   fwd_sel = mem_val;
      2'b10:   fwd_sel = wb_val;
      default: fwd_sel = rf_val;
    endcase
  endfunction

  // Single-operand tests only look at the sign bit and a zero detect of Op1.
  function automatic logic branch_cond(
    input logic [2:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic neg;
    logic zero;
    neg  = a[DATA_WIDTH-1];
    zero = (a == DATA_ZERO);
    case (op)
      3'b000:  branch_cond = (a == b);
      3'b001:  branch_cond = (a != b);
      3'b010:  branch_cond = neg | zero;
      3'b011:  branch_cond = ~neg & ~zero;
      3'b100:  branch_cond = neg;
      3'b101:  branch_cond = ~neg;
      default: branch_cond = 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    sat_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  logic [DATA_WIDTH-1:0] w_op1;
  logic [DATA_WIDTH-1:0] w_op2;
  logic                  w_cond;
  logic                  w_stall;
  logic                  w_resolve;
  logic                  w_taken;
  logic                  w_timeout_hit;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [WAIT_W-1:0]     w_wait_nxt;
  logic                  r_flush;
  logic                  r_last_taken;
  logic                  r_timeout;
  logic [CNT_WIDTH-1:0]  r_branch_cnt;
  logic [CNT_WIDTH-1:0]  r_taken_cnt;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;

  assign w_op1     = fwd_sel(Forward_C_ID, Read_Data_1_ID, Alu_Result_MEM, Write_Data_WB);
  assign w_op2     = fwd_sel(Forward_D_ID, Read_Data_2_ID, Alu_Result_MEM, Write_Data_WB);
  assign w_cond    = branch_cond(Branch_Op_ID, w_op1, w_op2);
  assign w_stall   = Branch_ID & Operand_Pending_ID;
  assign w_resolve = Branch_ID & ~Operand_Pending_ID;
  assign w_taken   = w_resolve & w_cond;

  assign Zero_ID        = (w_op1 == w_op2);
  assign Stall_ID       = w_stall;
  assign Taken_ID       = w_taken;
  assign Flush_IF       = r_flush;
  assign Last_Taken     = r_last_taken;
  assign Timeout_Err_ID = r_timeout;
  assign Branch_Count   = r_branch_cnt;
  assign Taken_Count    = r_taken_cnt;
  assign Stall_Count    = r_stall_cnt;

  // Next state and wait length; both resolve and squash leave WAIT and drop the count.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_stall) begin
          w_state_nxt = ST_WAIT;
          w_wait_nxt  = WAIT_ONE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = WAIT_ZERO;
        end
      end
      ST_WAIT: begin
        if (w_stall) begin
          w_state_nxt = ST_WAIT;
          w_wait_nxt  = (r_wait_cnt >= WAIT_LIMIT) ? WAIT_LIMIT : r_wait_cnt + WAIT_ONE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = WAIT_ZERO;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wait_nxt  = WAIT_ZERO;
      end
    endcase
  end

  assign w_timeout_hit = w_stall & (w_wait_nxt >= WAIT_LIMIT);

  // FSM state and wait counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= WAIT_ZERO;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Flush pulse, last outcome and sticky timeout flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_flush      <= 1'b0;
      r_last_taken <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_flush   <= w_taken;
      r_timeout <= r_timeout | w_timeout_hit;
      if (w_resolve) begin
        r_last_taken <= w_cond;
      end else begin
        r_last_taken <= r_last_taken;
      end
    end
  end

  // Saturating statistics; a clear wins over any same-cycle increment.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_branch_cnt <= CNT_ZERO;
      r_taken_cnt  <= CNT_ZERO;
      r_stall_cnt  <= CNT_ZERO;
    end else if (Clear_Stats) begin
      r_branch_cnt <= CNT_ZERO;
      r_taken_cnt  <= CNT_ZERO;
      r_stall_cnt  <= CNT_ZERO;
    end else begin
      r_branch_cnt <= w_resolve ? sat_inc(r_branch_cnt) : r_branch_cnt;
      r_taken_cnt  <= w_taken   ? sat_inc(r_taken_cnt)  : r_taken_cnt;
      r_stall_cnt  <= w_stall   ? sat_inc(r_stall_cnt)  : r_stall_cnt;
    end
  end

endmodule

// File: doc/id_branch_resolver.md
# id_branch_resolver

Parametrised ID-stage branch resolver: selects each branch operand from the register file, MEM-stage ALU result or WB write data, evaluates one of six MIPS branch conditions, and stalls the ID stage while an operand is still in flight. It sits in ID beside the register file and drives the PC-select and IF/ID flush logic. A small FSM tracks multi-cycle branch stalls and flags overlong waits. Saturating counters record branch, taken and stall statistics.

## Interface
- DATA_WIDTH, 32, operand width
- CNT_WIDTH, 16, width of each statistics counter
- MAX_WAIT, 3, stall cycles allowed for one branch before Timeout_Err_ID sets; must be ≥1
- Clk  input  1  rising-edge clock; the only clock
- Reset_n  input  1  asynchronous, active-low reset
- Read_Data_1_ID, Read_Data_2_ID  input  DATA_WIDTH  register-file operands
- Alu_Result_MEM  input  DATA_WIDTH  MEM-stage forward source
- Write_Data_WB  input  DATA_WIDTH  WB-stage forward source
- Forward_C_ID, Forward_D_ID  input  2  operand 1 / operand 2 select: 00 regfile, 01 MEM, 10 WB, 11 regfile
- Branch_ID  input  1  a branch instruction is in ID
- Branch_Op_ID  input  3  000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ, 11x never taken
- Operand_Pending_ID  input  1  a needed operand is not yet forwardable (load in EX/MEM)
- Clear_Stats  input  1  synchronous clear of all counters
- Zero_ID  output  1  muxed operand 1 == muxed operand 2
- Stall_ID  output  1  hold PC and IF/ID
- Taken_ID  output  1  branch resolves taken this cycle
- Flush_IF  output  1  registered one-cycle flush pulse
- Last_Taken  output  1  outcome of the most recent resolved branch
- Timeout_Err_ID  output  1  sticky: a branch stalled for MAX_WAIT or more cycles
- Branch_Count, Taken_Count, Stall_Count  output  CNT_WIDTH  statistics

## Operation
- Operand mux: Op1 and Op2 selected per Forward_C_ID / Forward_D_ID; combinational.
- Conditions: BEQ Op1==Op2; BNE Op1!=Op2; BLEZ/BGTZ/BLTZ/BGEZ compare Op1 against zero, signed (two's complement, MSB is sign); Op2 ignored.
- Stall_ID = Branch_ID & Operand_Pending_ID (combinational, any state).
- Resolve = Branch_ID & ~Operand_Pending_ID; Taken_ID = Resolve & condition.
- FSM, two states:
  - IDLE: Branch_ID & Operand_Pending_ID → WAIT, wait counter loads 1. Otherwise stays in IDLE.
  - WAIT: Operand_Pending_ID still high → stay, wait counter +1 (saturating). Resolve → IDLE. Branch_ID low (upstream squash) → IDLE without resolving, no counter updates.
- Timeout: the cycle the wait counter would reach MAX_WAIT, Timeout_Err_ID sets. It is cleared only by reset. Stalling continues regardless.
- Counters: Branch_Count +1 per Resolve; Taken_Count +1 per Taken_ID; Stall_Count +1 per Stall_ID cycle. All saturate at 2^CNT_WIDTH−1. Clear_Stats zeroes all three and has priority over a same-cycle increment.
- Last_Taken updates to the condition on each Resolve and holds otherwise.

## Timing
- Reset (async assert, sync release): FSM IDLE, wait counter 0, Flush_IF 0, Last_Taken 0, Timeout_Err_ID 0, all counters 0. Combinational outputs follow their inputs during reset.
- Zero_ID, Stall_ID and Taken_ID have zero latency, valid in the same cycle as their inputs.
- Flush_IF is high exactly in the cycle after Taken_ID=1, for one cycle. Back-to-back taken branches give back-to-back pulses.
- Counters, Last_Taken and Timeout_Err_ID are visible the cycle after the triggering event.
- A stall lasting N cycles followed by a resolve gives Stall_Count +N and Branch_Count +1.
- Reset asserted mid-WAIT returns to IDLE immediately. No counter updates occur for the aborted branch.

## Test plan
- Forward mux: Read_Data_1_ID=5, Alu_Result_MEM=7, Read_Data_2_ID=7, Forward_C_ID=01, Forward_D_ID=00, BEQ → Zero_ID=1, Taken_ID=1, Flush_IF=1 the next cycle only, Branch_Count=1, Taken_Count=1.
- Signed ops: Op1=0xFFFFFFFF with BLTZ → taken; BGEZ → not taken; BLEZ with Op1=0 → taken; BGTZ with Op1=0 → not taken; Branch_Op_ID=110 → never taken.
- Load-use stall: BEQ with Operand_Pending_ID high for 2 cycles, then low with Forward_C_ID=10 and equal operands → Stall_ID high 2 cycles, taken on cycle 3, Stall_Count=2, Timeout_Err_ID=0.
- Timeout and squash: MAX_WAIT=3 with pending held 3 cycles → Timeout_Err_ID=1 (sticky). A separate branch where Branch_ID drops in WAIT → FSM returns to IDLE, Branch_Count unchanged.
- Saturation and clear: CNT_WIDTH=4 with 17 taken resolves → Branch_Count=Taken_Count=15. Clear_Stats coinciding with a resolve → all counters 0.
- Async reset mid-WAIT: Reset_n low between clock edges → Last_Taken, Flush_IF and counters go to 0 immediately, and the FSM is in IDLE after release.
